tilt_decoder: RTL and testbench

//  Converts raw accelerometer samples from the SPI accelerometer controller into the per-axis
//  x/y increment/decrement levels consumed by the Ball stage.

---
 rtl/tilt_decoder_pkg.sv | 21 ++
 rtl/tilt_decoder_axis.sv | 72 +++++++
 rtl/tilt_decoder.sv | 111 +++++++++++
 tb/tb_tilt_decoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tilt_decoder_pkg.sv
// Shared definitions for the tilt decoder: sample width, axis FSM states,
// and the saturating negation used by the input conditioning.
package tilt_decoder_pkg;

  localparam int SAMPLE_W = 12;

  typedef enum logic [1:0] {
    TILT_ZERO = 2'd0,
    TILT_POS  = 2'd1,
    TILT_NEG  = 2'd2
  } tilt_state_e;

  // Two's-complement negation that maps the most negative code to the most positive one
  function automatic logic signed [SAMPLE_W-1:0] neg_sat(input logic signed [SAMPLE_W-1:0] v);
    if (v == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
      return {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
    return -v;
  endfunction

endpackage

// File: rtl/tilt_decoder_axis.sv
// One tilt axis: block accumulator, registered window average and the
// NEG/ZERO/POS hysteresis FSM evaluated one cycle after the average lands.
module tilt_decoder_axis
  import tilt_decoder_pkg::*;
#(
  parameter int AVG_LOG2   = 2,
  parameter int ON_THRESH  = 200,
  parameter int OFF_THRESH = 120
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       sample_valid,
  input  logic                       window_last,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       eval,
  output tilt_state_e                state
);

  localparam int ACC_W = SAMPLE_W + AVG_LOG2;

  logic signed [ACC_W-1:0]    acc_reg;
  logic signed [ACC_W-1:0]    sum_next;
  logic signed [SAMPLE_W-1:0] avg_reg;
  logic signed [SAMPLE_W-1:0] avg_next;
  tilt_state_e                state_reg;

  // The completing sample is folded into the average; the shift floors toward -inf
  assign sum_next = acc_reg + ACC_W'(sample);
  assign avg_next = SAMPLE_W'(sum_next >>> AVG_LOG2);

  // Accumulate samples and register the average when a window completes
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_reg <= '0;
      avg_reg <= '0;
    end else if (sample_valid) begin
      if (window_last) begin
        avg_reg <= avg_next;
        acc_reg <= '0;
      end else begin
        acc_reg <= sum_next;
      end
    end
  end

  // Hysteresis FSM: strong opposite tilt reverses directly, weak tilt drops to ZERO
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_reg <= TILT_ZERO;
    end else if (eval) begin
      case (state_reg)
        TILT_ZERO: begin
          if (avg_reg > ON_THRESH)       state_reg <= TILT_POS;
          else if (avg_reg < -ON_THRESH) state_reg <= TILT_NEG;
        end
        TILT_POS: begin
          if (avg_reg < -ON_THRESH)      state_reg <= TILT_NEG;
          else if (avg_reg < OFF_THRESH) state_reg <= TILT_ZERO;
        end
        TILT_NEG: begin
          if (avg_reg > ON_THRESH)        state_reg <= TILT_POS;
          else if (avg_reg > -OFF_THRESH) state_reg <= TILT_ZERO;
        end
        default: state_reg <= TILT_ZERO;
      endcase
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/tilt_decoder.sv
// Tilt decoder top: conditions accelerometer samples (swap, then invert),
// runs the shared window counter and stall watchdog, and drives the
// per-axis direction levels plus the window-evaluated pulse.
module tilt_decoder
  import tilt_decoder_pkg::*;
#(
  parameter int AVG_LOG2       = 2,
  parameter int ON_THRESH      = 200,
  parameter int OFF_THRESH     = 120,
  parameter int TIMEOUT_CYCLES = 10000000,
  parameter int INVERT_X       = 0,
  parameter int INVERT_Y       = 0,
  parameter int SWAP_XY        = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] accel_x,
  input  logic signed [SAMPLE_W-1:0] accel_y,
  input  logic                       accel_valid,
  output logic                       x_increment,
  output logic                       x_decrement,
  output logic                       y_increment,
  output logic                       y_decrement,
  output logic                       tilt_update
);

  localparam int CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int WIN_LAST = (1 << AVG_LOG2) - 1;
  localparam int WD_W     = $clog2(TIMEOUT_CYCLES + 1);

  logic signed [SAMPLE_W-1:0] x_src, y_src, x_cond, y_cond;
  logic [CNT_W-1:0]           win_cnt_reg;
  logic [WD_W-1:0]            wd_reg;
  logic                       eval_reg;
  logic                       window_last;
  logic                       timeout_fire;
  tilt_state_e                x_state, y_state;

  assign x_src  = (SWAP_XY != 0) ? accel_y : accel_x;
  assign y_src  = (SWAP_XY != 0) ? accel_x : accel_y;
  assign x_cond = (INVERT_X != 0) ? neg_sat(x_src) : x_src;
  assign y_cond = (INVERT_Y != 0) ? neg_sat(y_src) : y_src;

  assign window_last = (win_cnt_reg == CNT_W'(WIN_LAST));
  // A valid in the timeout cycle takes priority, so the stall is only declared when idle
  assign timeout_fire = !accel_valid && (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));

  // Shared window position; restarts on completion or after a stall
  always_ff @(posedge clk) begin
    if (reset || timeout_fire) begin
      win_cnt_reg <= '0;
    end else if (accel_valid) begin
      win_cnt_reg <= window_last ? '0 : win_cnt_reg + CNT_W'(1);
    end
  end

  // Stall watchdog: counts idle cycles and saturates at the timeout
  always_ff @(posedge clk) begin
    if (reset || accel_valid) begin
      wd_reg <= '0;
    end else if (wd_reg != WD_W'(TIMEOUT_CYCLES)) begin
      wd_reg <= wd_reg + WD_W'(1);
    end
  end

  // Evaluate-next-cycle strobe, which is also the externally visible update pulse
  always_ff @(posedge clk) begin
    if (reset || timeout_fire) begin
      eval_reg <= 1'b0;
    end else begin
      eval_reg <= accel_valid && window_last;
    end
  end

  tilt_decoder_axis #(
    .AVG_LOG2   (AVG_LOG2),
    .ON_THRESH  (ON_THRESH),
    .OFF_THRESH (OFF_THRESH)
  ) u_axis_x (
    .clk          (clk),
    .reset        (reset),
    .clear        (timeout_fire),
    .sample_valid (accel_valid),
    .window_last  (window_last),
    .sample       (x_cond),
    .eval         (eval_reg),
    .state        (x_state)
  );

  tilt_decoder_axis #(
    .AVG_LOG2   (AVG_LOG2),
    .ON_THRESH  (ON_THRESH),
    .OFF_THRESH (OFF_THRESH)
  ) u_axis_y (
    .clk          (clk),
    .reset        (reset),
    .clear        (timeout_fire),
    .sample_valid (accel_valid),
    .window_last  (window_last),
    .sample       (y_cond),
    .eval         (eval_reg),
    .state        (y_state)
  );

  assign x_increment = (x_state == TILT_POS);
  assign x_decrement = (x_state == TILT_NEG);
  assign y_increment = (y_state == TILT_POS);
  assign y_decrement = (y_state == TILT_NEG);
  assign tilt_update = eval_reg;

endmodule

// File: tb/tb_tilt_decoder.sv
// Testbench for tilt_decoder: two instances (plain, and swapped with x inverted)
// share the stimulus; every cycle both are compared against a window-average model.
module tb_tilt_decoder;

  localparam int TMO = 50;
  localparam int WIN = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [11:0] ax = '0, ay = '0;
  logic av = 1'b0;
  logic a_xi, a_xd, a_yi, a_yd, a_tu;
  logic b_xi, b_xd, b_yi, b_yd, b_tu;

  int checks = 0;
  int errors = 0;

  // Model state, indexed [dut][axis]; state codes: 0 zero, 1 pos, 2 neg
  int m_sum [2][2];
  int m_pavg[2][2];
  int m_st  [2][2];
  int m_n   [2];
  int m_idle[2];
  bit m_pend[2];

  always #5 clk = ~clk;

  tilt_decoder #(.AVG_LOG2(2), .TIMEOUT_CYCLES(TMO)) dut_a (
    .clk(clk), .reset(reset), .accel_x(ax), .accel_y(ay), .accel_valid(av),
    .x_increment(a_xi), .x_decrement(a_xd), .y_increment(a_yi), .y_decrement(a_yd),
    .tilt_update(a_tu)
  );

  tilt_decoder #(.AVG_LOG2(2), .TIMEOUT_CYCLES(TMO), .INVERT_X(1), .SWAP_XY(1)) dut_b (
    .clk(clk), .reset(reset), .accel_x(ax), .accel_y(ay), .accel_valid(av),
    .x_increment(b_xi), .x_decrement(b_xd), .y_increment(b_yi), .y_decrement(b_yd),
    .tilt_update(b_tu)
  );

  function automatic int cond(int d, int axis, int x, int y);
    int v;
    if (d == 1) begin
      v = (axis == 0) ? y : x;
      if (axis == 0) v = (v == -2048) ? 2047 : -v;
    end else begin
      v = (axis == 0) ? x : y;
    end
    return v;
  endfunction

  function automatic int fdiv(int s, int dv);
    int q = s / dv;
    if ((s % dv) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic int fsm(int s, int avg);
    case (s)
      0:       return (avg > 200) ? 1 : (avg < -200) ? 2 : 0;
      1:       return (avg < -200) ? 2 : (avg < 120) ? 0 : 1;
      default: return (avg > 200) ? 1 : (avg > -120) ? 0 : 2;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 2; a++) begin
        m_sum[d][a] = 0; m_pavg[d][a] = 0; m_st[d][a] = 0;
      end
      m_n[d] = 0; m_idle[d] = 0; m_pend[d] = 0;
    end
  endtask

  task automatic model_edge(bit v, int x, int y);
    for (int d = 0; d < 2; d++) begin
      if (m_pend[d]) begin
        for (int a = 0; a < 2; a++) m_st[d][a] = fsm(m_st[d][a], m_pavg[d][a]);
        m_pend[d] = 0;
      end
      if (v) begin
        m_idle[d] = 0;
        for (int a = 0; a < 2; a++) m_sum[d][a] += cond(d, a, x, y);
        m_n[d]++;
        if (m_n[d] == WIN) begin
          for (int a = 0; a < 2; a++) begin
            m_pavg[d][a] = fdiv(m_sum[d][a], WIN);
            m_sum[d][a] = 0;
          end
          m_n[d] = 0;
          m_pend[d] = 1;
        end
      end else begin
        m_idle[d]++;
        if (m_idle[d] == TMO) begin
          for (int a = 0; a < 2; a++) begin
            m_st[d][a] = 0; m_sum[d][a] = 0;
          end
          m_n[d] = 0;
        end
      end
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk1("a_xi", a_xi, m_st[0][0] == 1);
    chk1("a_xd", a_xd, m_st[0][0] == 2);
    chk1("a_yi", a_yi, m_st[0][1] == 1);
    chk1("a_yd", a_yd, m_st[0][1] == 2);
    chk1("a_tu", a_tu, m_pend[0]);
    chk1("b_xi", b_xi, m_st[1][0] == 1);
    chk1("b_xd", b_xd, m_st[1][0] == 2);
    chk1("b_yi", b_yi, m_st[1][1] == 1);
    chk1("b_yd", b_yd, m_st[1][1] == 2);
    chk1("b_tu", b_tu, m_pend[1]);
  endtask

  // Called at a negedge: drive this cycle's inputs, check, advance model, move to next negedge
  task automatic step(bit v, int x, int y);
    reset = 1'b0;
    av = v;
    ax = 12'(x);
    ay = 12'(y);
    chk_all();
    model_edge(v, x, y);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    av = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic window(int x, int y);
    repeat (WIN) step(1, x, y);
  endtask

  int upd_seen;
  int lvl_x, lvl_y, sx, sy;

  initial begin
    model_reset();
    @(negedge clk);
    do_reset(3);

    // Idle after reset: no direction, no update pulse
    upd_seen = 0;
    repeat (20) begin
      if (a_tu) upd_seen++;
      step(0, 0, 0);
    end
    chk1("idle_no_update", upd_seen != 0, 1'b0);
    chk1("idle_xi", a_xi, 1'b0);

    // Four valids of x=300: update pulse at c+1, x_increment from c+2
    window(300, 0);
    chk1("w300_tu", a_tu, 1'b1);
    chk1("w300_xi_c1", a_xi, 1'b0);
    step(0, 0, 0);
    chk1("w300_xi_c2", a_xi, 1'b1);
    chk1("w300_yi", a_yi, 1'b0);
    chk1("w300_tu_once", a_tu, 1'b0);

    // Hysteresis: 150 holds POS, 100 drops to ZERO
    window(150, 0); step(0, 0, 0); step(0, 0, 0);
    chk1("hyst150_xi", a_xi, 1'b1);
    window(100, 0); step(0, 0, 0); step(0, 0, 0);
    chk1("hyst100_xi", a_xi, 1'b0);

    // Threshold edges from ZERO, then direct reversal
    window(200, 0); step(0, 0, 0); step(0, 0, 0);
    chk1("thr200_xi", a_xi, 1'b0);
    window(201, 0); step(0, 0, 0); step(0, 0, 0);
    chk1("thr201_xi", a_xi, 1'b1);
    window(-250, 0); step(0, 0, 0); step(0, 0, 0);
    chk1("rev_xd", a_xd, 1'b1);
    chk1("rev_xi", a_xi, 1'b0);

    // Watchdog: POS, then valids stop; forced ZERO follows the 50th idle cycle
    window(300, 0);
    repeat (TMO - 1) step(0, 0, 0);
    chk1("wd_c50_xi", a_xi, 1'b1);
    step(0, 0, 0);
    chk1("wd_c51_xi", a_xi, 1'b0);

    // Valid landing on cycle 50 prevents the forced ZERO
    window(300, 0);
    repeat (TMO - 1) step(0, 0, 0);
    step(1, 300, 0);
    chk1("wd_valid50_xi", a_xi, 1'b1);
    repeat (WIN - 1) step(1, 300, 0);
    step(0, 0, 0); step(0, 0, 0);

    // Reset mid-window discards the partial sum
    do_reset(2);
    repeat (3) step(1, 2047, 0);
    do_reset(2);
    window(0, 0); step(0, 0, 0); step(0, 0, 0);
    chk1("rstmid_xi", a_xi, 1'b0);
    chk1("rstmid_xd", a_xd, 1'b0);

    // Saturating inversion: -2048 becomes +2047 on the inverted, swapped channel
    window(-2048, -2048); step(0, 0, 0); step(0, 0, 0);
    chk1("inv_b_xi", b_xi, 1'b1);
    chk1("inv_b_yd", b_yd, 1'b1);
    chk1("inv_a_xd", a_xd, 1'b1);

    // Randomized phase: level per window with noise, occasional stalls and resets
    for (int w = 0; w < 400; w++) begin
      lvl_x = int'($urandom_range(0, 1000)) - 500;
      lvl_y = int'($urandom_range(0, 1000)) - 500;
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 15) == 0) begin
          sx = ($urandom_range(0, 1) == 1) ? 2047 : -2048;
          sy = ($urandom_range(0, 1) == 1) ? 2047 : -2048;
        end else begin
          sx = lvl_x + int'($urandom_range(0, 200)) - 100;
          sy = lvl_y + int'($urandom_range(0, 200)) - 100;
        end
        step($urandom_range(0, 2) != 0, sx, sy);
      end
      if ($urandom_range(0, 19) == 0) begin
        repeat (int'($urandom_range(TMO - 3, TMO + 3))) step(0, 0, 0);
      end
      if ($urandom_range(0, 59) == 0) do_reset(1);
    end
    step(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
